// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with wrap-bit head/tail pointers and ready/valid on both sides.
// Status outputs depend only on pointer state, never combinationally on enq_valid/deq_ready.

module ring_fifo_ctr #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_aL,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_aL) begin
    if (!rst_aL) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= q + 1'b1;
    end
  end

endmodule

module ring_fifo #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_aL,
  input  logic                  flush,
  input  logic                  enq_valid,
  output logic                  enq_ready,
  input  logic [DATA_WIDTH-1:0] enq_data,
  output logic                  deq_valid,
  input  logic                  deq_ready,
  output logic [DATA_WIDTH-1:0] deq_data,
  output logic [ADDR_WIDTH:0]   count
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

  logic [ADDR_WIDTH:0]   head_ptr;
  logic [ADDR_WIDTH:0]   tail_ptr;
  logic [DATA_WIDTH-1:0] storage [DEPTH];

  logic empty;
  logic full;
  logic enq_fire;
  logic deq_fire;

  always_comb begin
    empty = (head_ptr == tail_ptr);
    full  = (head_ptr[ADDR_WIDTH-1:0] == tail_ptr[ADDR_WIDTH-1:0]) &&
            (head_ptr[ADDR_WIDTH] != tail_ptr[ADDR_WIDTH]);
    count     = tail_ptr - head_ptr;
    enq_ready = !full;
    deq_valid = !empty;
    enq_fire  = enq_valid && enq_ready && !flush;
    deq_fire  = deq_valid && deq_ready && !flush;
  end

  ring_fifo_ctr #(.W(ADDR_WIDTH + 1)) u_tail (
    .clk    (clk),
    .rst_aL (rst_aL),
    .clr    (flush),
    .en     (enq_fire),
    .q      (tail_ptr)
  );

  ring_fifo_ctr #(.W(ADDR_WIDTH + 1)) u_head (
    .clk    (clk),
    .rst_aL (rst_aL),
    .clr    (flush),
    .en     (deq_fire),
    .q      (head_ptr)
  );

  // Storage is intentionally not reset; flush leaves contents stale.
  always_ff @(posedge clk) begin
    if (enq_fire) begin
      storage[tail_ptr[ADDR_WIDTH-1:0]] <= enq_data;
    end
  end

  assign deq_data = storage[head_ptr[ADDR_WIDTH-1:0]];

endmodule

// File: doc/ring_fifo.md
Name: ring_fifo

Overview:
- Synchronous circular-buffer FIFO for decoupling pipeline stages, e.g. fetch→decode instruction queue.
- Head and tail pointers are wrap-bit counters: each is a register plus a +1 adder with write-enable, built from the team's standard counter.
- Ready/valid on both sides; exposes occupancy for upstream backpressure and stall logic.

Parameters:
- DATA_WIDTH, 32, width of each entry in bits.
- ADDR_WIDTH, 3, log2 of depth; DEPTH = 2**ADDR_WIDTH entries; must be ≥1.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst_aL  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear: discard all entries.
- enq_valid  input  1  producer has data.
- enq_ready  output  1  FIFO can accept an entry (= !full).
- enq_data  input  DATA_WIDTH  data to enqueue.
- deq_valid  output  1  FIFO holds ≥1 entry (= !empty).
- deq_ready  input  1  consumer takes the head entry.
- deq_data  output  DATA_WIDTH  head entry; meaningful only while deq_valid=1.
- count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- State:
  - head_ptr and tail_ptr, each ADDR_WIDTH+1 bits. MSB is the wrap bit; the low ADDR_WIDTH bits index storage.
  - Storage array of DEPTH × DATA_WIDTH. Storage is not reset.
- Reset (rst_aL=0, asynchronous): head_ptr=0, tail_ptr=0. Outputs settle immediately to count=0, deq_valid=0, enq_ready=1.
- Status (combinational from pointers):
  - empty = (head_ptr == tail_ptr).
  - full = (low bits equal) && (wrap bits differ).
  - count = tail_ptr − head_ptr, modulo 2**(ADDR_WIDTH+1).
- Enqueue fire:
  - Condition: enq_valid && enq_ready && !flush.
  - At the edge: storage[tail_ptr low bits] <= enq_data; tail_ptr <= tail_ptr+1.
- Dequeue fire:
  - Condition: deq_valid && deq_ready && !flush.
  - At the edge: head_ptr <= head_ptr+1.
- deq_data:
  - Combinational read of storage[head_ptr low bits]. No registered output stage.
  - Value when empty is don't-care, but must not be X-propagated into control.
- Latency: an entry enqueued at edge N is visible on deq_data, with deq_valid=1, in the cycle after edge N. There is no same-cycle fall-through when empty.
- Simultaneous enq and deq fire (neither full nor empty): both pointers advance and count is unchanged.
- When full:
  - enq_ready=0, so enqueue cannot fire even if deq fires in the same cycle. There is no write-through-on-full.
  - Dequeue proceeds normally; enq_ready rises the cycle after.
- When empty: deq_valid=0, and deq_ready is ignored.
- Pointer wrap: the +1 wraps naturally at 2**(ADDR_WIDTH+1). The wrap bit toggles each time an index passes DEPTH−1 → 0.
- flush=1 at an edge:
  - head_ptr <= 0 and tail_ptr <= 0, regardless of enq/deq activity.
  - Any enqueue offered that cycle is dropped.
  - Storage contents are left stale.
  - flush has priority over enqueue and dequeue.
- Reset mid-operation: the asynchronous clear takes effect immediately, with no dependence on the clock. The first edge after rst_aL deasserts behaves as from an empty FIFO.
- enq_ready and deq_valid depend only on state, never combinationally on deq_ready or enq_valid. This avoids combinational loops across stages.

Test Plan:
1. Reset, then enqueue 0xA0..0xA7 on consecutive cycles (DEPTH=8) with deq_ready=0 → count steps 1..8; enq_ready=0 after the 8th; a 9th offer of 0xFF is not accepted.
2. From full, dequeue all with deq_ready=1 → deq_data reads 0xA0..0xA7 in order; deq_valid falls after the 8th; count=0.
3. Wrap test: interleave 20 enqueues (values 0..19) and 20 dequeues with random gaps → output order 0..19 exact; count never exceeds 8 or underflows; wrap bits toggle at least twice.
4. Simultaneous enq+deq with count=3 for 10 cycles → count stays 3; the output sequence matches the input delayed by 3 entries.
5. With count=5, assert flush together with enq_valid=1 and data 0x55 → next cycle count=0, deq_valid=0; 0x55 is never dequeued.
6. Enqueue 4 entries, pulse rst_aL low mid-cycle with no clock edge → count=0 and deq_valid=0 immediately; after release, enqueue 0x11 → dequeue returns 0x11.
